// File: rtl/wb_cmd_pkg.sv
// Shared definitions for the Wishbone command master: FSM states and the
// layout of a queued command word.
package wb_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CMD_W       = 1 + 32 + 32 + 4;
    localparam int CMD_SEL_LSB = 0;
    localparam int CMD_DAT_LSB = 4;
    localparam int CMD_ADR_LSB = 36;
    localparam int CMD_WE_BIT  = 68;

    // Wide enough for the largest legal TIMEOUT (65535).
    localparam int CNT_W = 16;

    function automatic logic [CMD_W-1:0] pack_cmd(
        input logic        we,
        input logic [31:0] adr,
        input logic [31:0] dat,
        input logic [3:0]  sel
    );
        logic [CMD_W-1:0] word;
        word                     = '0;
        word[CMD_WE_BIT]         = we;
        word[CMD_ADR_LSB +: 32]  = adr;
        word[CMD_DAT_LSB +: 32]  = dat;
        word[CMD_SEL_LSB +: 4]   = sel;
        return word;
    endfunction

endpackage

// File: rtl/wb_cmd_master_if.sv
// Command, response and Wishbone bus signals of wb_cmd_master; the master
// modport is the block's view, the slave modport is its environment's view.
interface wb_cmd_master_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        busy;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
        input  rsp_ready, wbm_ack_i, wbm_dat_i,
        output cmd_ready, rsp_valid, rsp_dat, rsp_err, busy,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
        output rsp_ready, wbm_ack_i, wbm_dat_i,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_err, busy,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

endinterface

// File: rtl/wb_cmd_fifo.sv
// Synchronous FIFO with first-word-fall-through read data; pointers carry an
// extra wrap bit so full and empty can be told apart.
module wb_cmd_fifo #(
    parameter int WIDTH = 69,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-cycle initiator: queues commands, runs one bus
// transaction per command and returns read data or a timeout flag.
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int FIFO_AW = 2,
    parameter int TIMEOUT = 64
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    wb_cmd_master_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q;
    state_t           state_d;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CMD_W-1:0] fifo_din;
    logic [CMD_W-1:0] fifo_dout;
    logic [CNT_W-1:0] cnt_q;
    logic             expired;
    logic             ready_q;
    logic             we_q;
    logic [31:0]      adr_q;
    logic [31:0]      dat_q;
    logic [3:0]       sel_q;
    logic [31:0]      rsp_dat_q;
    logic             rsp_err_q;

    assign fifo_push = bus.cmd_valid && bus.cmd_ready;
    assign fifo_din  = pack_cmd(bus.cmd_we, bus.cmd_adr, bus.cmd_dat, bus.cmd_sel);
    assign expired   = (cnt_q == CNT_LAST);

    wb_cmd_fifo #(
        .WIDTH (CMD_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (wb_clk_i),
        .reset   (wb_rst_i),
        .push    (fifo_push),
        .wr_data (fifo_din),
        .pop     (fifo_pop),
        .rd_data (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Ack takes priority over timeout expiry when both land in the same cycle.
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = BUS;
                end
            end
            BUS: begin
                if (bus.wbm_ack_i || expired) state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ready_q keeps cmd_ready low until the first clock edge after reset release.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ready_q   <= 1'b0;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (fifo_pop) begin
                        we_q  <= fifo_dout[CMD_WE_BIT];
                        adr_q <= fifo_dout[CMD_ADR_LSB +: 32];
                        dat_q <= fifo_dout[CMD_DAT_LSB +: 32];
                        sel_q <= fifo_dout[CMD_SEL_LSB +: 4];
                        cnt_q <= '0;
                    end
                end
                BUS: begin
                    if (bus.wbm_ack_i) begin
                        rsp_dat_q <= we_q ? 32'd0 : bus.wbm_dat_i;
                        rsp_err_q <= 1'b0;
                    end else if (expired) begin
                        rsp_dat_q <= 32'd0;
                        rsp_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_dat_q <= 32'd0;
                        rsp_err_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready = ready_q && !fifo_full;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_dat   = rsp_dat_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = (state_q != IDLE) || !fifo_empty;
    assign bus.wbm_cyc_o = (state_q == BUS);
    assign bus.wbm_stb_o = (state_q == BUS);
    assign bus.wbm_we_o  = we_q;
    assign bus.wbm_adr_o = adr_q;
    assign bus.wbm_dat_o = dat_q;
    assign bus.wbm_sel_o = sel_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: one instance with TIMEOUT=8 and one with
// TIMEOUT=4, each driven through its own interface by a hand-written slave.
module tb_wb_cmd_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   acc8 = 0;

    wb_cmd_master_if bus8 ();
    wb_cmd_master_if bus4 ();

    wb_cmd_master #(.FIFO_AW(2), .TIMEOUT(8)) dut8 (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus8)
    );

    wb_cmd_master #(.FIFO_AW(2), .TIMEOUT(4)) dut4 (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus4)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; an offered command that met cmd_ready is retired after the edge.
    task automatic tick();
        logic a8;
        logic a4;
        a8 = bus8.cmd_valid && bus8.cmd_ready;
        a4 = bus4.cmd_valid && bus4.cmd_ready;
        @(posedge clk);
        #1;
        if (a8) begin
            bus8.cmd_valid = 1'b0;
            acc8++;
        end
        if (a4) bus4.cmd_valid = 1'b0;
    endtask

    task automatic apply_stimulus(input bit on4, input logic we, input logic [31:0] adr,
                                  input logic [31:0] dat, input logic [3:0] sel);
        if (on4) begin
            bus4.cmd_we = we; bus4.cmd_adr = adr; bus4.cmd_dat = dat; bus4.cmd_sel = sel;
            bus4.cmd_valid = 1'b1;
        end else begin
            bus8.cmd_we = we; bus8.cmd_adr = adr; bus8.cmd_dat = dat; bus8.cmd_sel = sel;
            bus8.cmd_valid = 1'b1;
        end
    endtask

    task automatic push_cmd(input bit on4, input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel, input string tag);
        int n;
        n = 0;
        apply_stimulus(on4, we, adr, dat, sel);
        while (n < 20 && (on4 ? bus4.cmd_valid : bus8.cmd_valid)) begin
            tick();
            n++;
        end
        check_output({tag, "_accepted"}, on4 ? bus4.cmd_valid : bus8.cmd_valid, 32'd0);
    endtask

    task automatic serve8(input logic [31:0] exp_adr, input logic exp_we,
                          input logic [31:0] rdata, input string tag);
        int n;
        n = 0;
        while (n < 16 && !bus8.wbm_cyc_o) begin
            tick();
            n++;
        end
        check_output({tag, "_cyc"}, bus8.wbm_cyc_o, 32'd1);
        check_output({tag, "_adr"}, bus8.wbm_adr_o, exp_adr);
        check_output({tag, "_we"}, bus8.wbm_we_o, exp_we);
        bus8.wbm_ack_i = 1'b1;
        bus8.wbm_dat_i = rdata;
        tick();
        bus8.wbm_ack_i = 1'b0;
        bus8.wbm_dat_i = 32'd0;
    endtask

    task automatic take_rsp(input bit on4, input logic [31:0] exp_dat, input logic exp_err,
                            input string tag);
        int n;
        n = 0;
        while (n < 16 && !(on4 ? bus4.rsp_valid : bus8.rsp_valid)) begin
            tick();
            n++;
        end
        check_output({tag, "_rsp_valid"}, on4 ? bus4.rsp_valid : bus8.rsp_valid, 32'd1);
        check_output({tag, "_rsp_dat"}, on4 ? bus4.rsp_dat : bus8.rsp_dat, exp_dat);
        check_output({tag, "_rsp_err"}, on4 ? bus4.rsp_err : bus8.rsp_err, exp_err);
        if (on4) bus4.rsp_ready = 1'b1; else bus8.rsp_ready = 1'b1;
        tick();
        bus4.rsp_ready = 1'b0;
        bus8.rsp_ready = 1'b0;
    endtask

    initial begin
        int n;
        logic seen;
        bus8.cmd_valid = 0; bus8.cmd_we = 0; bus8.cmd_adr = 0; bus8.cmd_dat = 0; bus8.cmd_sel = 0;
        bus8.rsp_ready = 0; bus8.wbm_ack_i = 0; bus8.wbm_dat_i = 0;
        bus4.cmd_valid = 0; bus4.cmd_we = 0; bus4.cmd_adr = 0; bus4.cmd_dat = 0; bus4.cmd_sel = 0;
        bus4.rsp_ready = 0; bus4.wbm_ack_i = 0; bus4.wbm_dat_i = 0;

        // Reset state
        #3;
        check_output("rst_cyc", bus8.wbm_cyc_o, 32'd0);
        check_output("rst_rsp_valid", bus8.rsp_valid, 32'd0);
        check_output("rst_cmd_ready", bus8.cmd_ready, 32'd0);
        check_output("rst_busy", bus8.busy, 32'd0);
        #19;
        rst = 1'b0;
        tick();
        check_output("rel_cmd_ready", bus8.cmd_ready, 32'd1);

        $display("[TB] test 1: write");
        push_cmd(0, 1'b1, 32'h3000_0000, 32'hA5A5_0001, 4'hF, "t1");
        check_output("t1_cyc_k", bus8.wbm_cyc_o, 32'd0);
        check_output("t1_busy", bus8.busy, 32'd1);
        tick();
        check_output("t1_cyc", bus8.wbm_cyc_o, 32'd1);
        check_output("t1_stb", bus8.wbm_stb_o, 32'd1);
        check_output("t1_we", bus8.wbm_we_o, 32'd1);
        check_output("t1_adr", bus8.wbm_adr_o, 32'h3000_0000);
        check_output("t1_dat", bus8.wbm_dat_o, 32'hA5A5_0001);
        check_output("t1_sel", bus8.wbm_sel_o, 32'hF);
        bus8.wbm_dat_i = 32'hDEAD_BEEF;
        tick();
        check_output("t1_cyc2", bus8.wbm_cyc_o, 32'd1);
        check_output("t1_adr2", bus8.wbm_adr_o, 32'h3000_0000);
        check_output("t1_dat2", bus8.wbm_dat_o, 32'hA5A5_0001);
        bus8.wbm_ack_i = 1'b1;
        tick();
        bus8.wbm_ack_i = 1'b0;
        check_output("t1_cyc_end", bus8.wbm_cyc_o, 32'd0);
        check_output("t1_stb_end", bus8.wbm_stb_o, 32'd0);
        take_rsp(0, 32'd0, 1'b0, "t1");
        check_output("t1_rsp_gone", bus8.rsp_valid, 32'd0);
        check_output("t1_idle", bus8.busy, 32'd0);

        $display("[TB] test 2: read with stale ack");
        push_cmd(0, 1'b0, 32'h3000_0004, 32'd0, 4'hF, "t2");
        tick();
        check_output("t2_cyc", bus8.wbm_cyc_o, 32'd1);
        check_output("t2_we", bus8.wbm_we_o, 32'd0);
        bus8.wbm_ack_i = 1'b1;
        bus8.wbm_dat_i = 32'h0000_1234;
        tick();
        check_output("t2_cyc_end", bus8.wbm_cyc_o, 32'd0);
        check_output("t2_rsp_valid", bus8.rsp_valid, 32'd1);
        check_output("t2_rsp_dat", bus8.rsp_dat, 32'h0000_1234);
        bus8.wbm_dat_i = 32'hBAD0_0000;
        tick();
        check_output("t2_hold_valid", bus8.rsp_valid, 32'd1);
        check_output("t2_hold_dat", bus8.rsp_dat, 32'h0000_1234);
        check_output("t2_hold_err", bus8.rsp_err, 32'd0);
        bus8.rsp_ready = 1'b1;
        tick();
        bus8.rsp_ready = 1'b0;
        check_output("t2_rsp_gone", bus8.rsp_valid, 32'd0);
        tick();
        check_output("t2_no_extra_rsp", bus8.rsp_valid, 32'd0);
        check_output("t2_no_extra_cyc", bus8.wbm_cyc_o, 32'd0);
        check_output("t2_idle", bus8.busy, 32'd0);
        bus8.wbm_ack_i = 1'b0;
        bus8.wbm_dat_i = 32'd0;

        $display("[TB] test 3: timeout then next command");
        apply_stimulus(0, 1'b0, 32'h3000_0010, 32'd0, 4'hF);
        tick();
        apply_stimulus(0, 1'b1, 32'h3000_0014, 32'h1111_2222, 4'h3);
        tick();
        check_output("t3_b_accepted", bus8.cmd_valid, 32'd0);
        bus8.wbm_dat_i = 32'hFFFF_FFFF;
        n = 0;
        while (bus8.wbm_cyc_o && n < 20) begin
            n++;
            tick();
        end
        check_output("t3_cyc_cycles", n, 32'd8);
        check_output("t3_rsp_valid", bus8.rsp_valid, 32'd1);
        check_output("t3_rsp_err", bus8.rsp_err, 32'd1);
        check_output("t3_rsp_dat", bus8.rsp_dat, 32'd0);
        bus8.rsp_ready = 1'b1;
        tick();
        bus8.rsp_ready = 1'b0;
        bus8.wbm_dat_i = 32'd0;
        serve8(32'h3000_0014, 1'b1, 32'h7777_7777, "t3b");
        take_rsp(0, 32'd0, 1'b0, "t3b");

        $display("[TB] test 4: backpressure");
        acc8 = 0;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(0, 1'b0, 32'h3000_0100 + 32'(4 * i), 32'd0, 4'hF);
            tick();
        end
        check_output("t4_accepted5", acc8, 32'd5);
        apply_stimulus(0, 1'b0, 32'h3000_0114, 32'd0, 4'hF);
        tick();
        tick();
        check_output("t4_cmd_ready_low", bus8.cmd_ready, 32'd0);
        check_output("t4_still5", acc8, 32'd5);
        check_output("t4_busy", bus8.busy, 32'd1);
        check_output("t4_a_cyc", bus8.wbm_cyc_o, 32'd1);
        check_output("t4_a_adr", bus8.wbm_adr_o, 32'h3000_0100);
        bus8.wbm_ack_i = 1'b1;
        bus8.wbm_dat_i = 32'hC0DE_0000;
        tick();
        bus8.wbm_ack_i = 1'b0;
        bus8.wbm_dat_i = 32'd0;
        tick();
        check_output("t4_stall_valid", bus8.rsp_valid, 32'd1);
        check_output("t4_stall_ready", bus8.cmd_ready, 32'd0);
        take_rsp(0, 32'hC0DE_0000, 1'b0, "t4_0");
        for (int i = 1; i < 6; i++) begin
            serve8(32'h3000_0100 + 32'(4 * i), 1'b0, 32'hC0DE_0000 + 32'(i), $sformatf("t4_%0d", i));
            take_rsp(0, 32'hC0DE_0000 + 32'(i), 1'b0, $sformatf("t4_%0d", i));
        end
        check_output("t4_accepted6", acc8, 32'd6);
        check_output("t4_drained", bus8.busy, 32'd0);

        $display("[TB] test 5: reset mid-transaction");
        push_cmd(0, 1'b0, 32'h3000_0200, 32'd0, 4'hF, "t5");
        apply_stimulus(0, 1'b0, 32'h3000_0204, 32'd0, 4'hF);
        tick();
        check_output("t5_cyc_before", bus8.wbm_cyc_o, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_output("t5_cyc_async", bus8.wbm_cyc_o, 32'd0);
        check_output("t5_stb_async", bus8.wbm_stb_o, 32'd0);
        check_output("t5_rsp_valid_async", bus8.rsp_valid, 32'd0);
        check_output("t5_busy_async", bus8.busy, 32'd0);
        check_output("t5_cmd_ready_async", bus8.cmd_ready, 32'd0);
        #2;
        rst = 1'b0;
        tick();
        check_output("t5_cmd_ready_rel", bus8.cmd_ready, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus8.wbm_cyc_o || bus8.rsp_valid) seen = 1'b1;
            tick();
        end
        check_output("t5_no_activity", seen, 32'd0);

        $display("[TB] test 6: ack coinciding with timeout expiry");
        push_cmd(1, 1'b0, 32'h3000_0300, 32'd0, 4'hF, "t6");
        tick();
        check_output("t6_cyc", bus4.wbm_cyc_o, 32'd1);
        tick();
        tick();
        tick();
        check_output("t6_cyc_4th", bus4.wbm_cyc_o, 32'd1);
        bus4.wbm_ack_i = 1'b1;
        bus4.wbm_dat_i = 32'h0000_CAFE;
        tick();
        bus4.wbm_ack_i = 1'b0;
        bus4.wbm_dat_i = 32'd0;
        check_output("t6_cyc_end", bus4.wbm_cyc_o, 32'd0);
        take_rsp(1, 32'h0000_CAFE, 1'b0, "t6");
        push_cmd(1, 1'b0, 32'h3000_0304, 32'd0, 4'hF, "t6b");
        tick();
        n = 0;
        while (bus4.wbm_cyc_o && n < 20) begin
            n++;
            tick();
        end
        check_output("t6b_cyc_cycles", n, 32'd4);
        take_rsp(1, 32'd0, 1'b1, "t6b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
Wishbone classic single-cycle initiator. It is the bus-master counterpart to the team's Wishbone slave blocks.
- Accepts read/write commands on a valid/ready command port and buffers them in a small FIFO.
- Issues one Wishbone transaction per command.
- Returns the read data and an error flag (timeout) on a valid/ready response port.
- Used by test/debug logic (LA- or UART-driven) to drive user-area slaves such as the counter.

Parameters:
FIFO_AW, 2, log2 of command FIFO depth (depth = 4)
TIMEOUT, 64, cycles with cyc asserted before abandoning the transaction; legal range 2..65535

Ports:
wb_clk_i  input  1  single clock
wb_rst_i  input  1  reset, asynchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  command FIFO not full
cmd_we  input  1  1 = write, 0 = read
cmd_adr  input  32  byte address
cmd_dat  input  32  write data
cmd_sel  input  4  byte selects
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed
rsp_dat  output  32  read data (0 for writes and errors)
rsp_err  output  1  1 = timeout
busy  output  1  FIFO non-empty or state != IDLE
wbm_cyc_o  output  1  Wishbone cycle
wbm_stb_o  output  1  Wishbone strobe
wbm_we_o  output  1  Wishbone write enable
wbm_sel_o  output  4  Wishbone byte selects
wbm_adr_o  output  32  Wishbone address
wbm_dat_o  output  32  Wishbone write data
wbm_ack_i  input  1  Wishbone acknowledge
wbm_dat_i  input  32  Wishbone read data

Behaviour:
Reset (asynchronous, wb_rst_i = 1):
- All outputs 0 immediately; cmd_ready becomes 1 after reset release.
- FIFO emptied, timeout counter cleared, state = IDLE.
- A transaction in flight is dropped at once (cyc/stb fall asynchronously); no response is produced for it.

Command FIFO:
- cmd_ready = !full.
- Push on cmd_valid && cmd_ready; silent drop when not ready is impossible because the handshake is required.
- Push and pop in the same cycle are allowed when full or empty per normal FIFO rules.
- Pointers wrap modulo depth.

State machine (IDLE, BUS, RESP):
- IDLE: if FIFO non-empty, pop head, register we/adr/dat/sel, set cyc = stb = 1, go to BUS.
  - Latency: command accepted at edge k into an empty idle block -> cyc/stb high after edge k+1.
- BUS: cyc, stb, we, adr, dat and sel are held stable. The timeout counter increments each cycle, starting at 0 on BUS entry.
  - ack sampled high: cyc = stb = 0 at the same edge; rsp_dat = we ? 0 : wbm_dat_i; rsp_err = 0; go to RESP.
  - No ack and counter == TIMEOUT-1: cyc = stb = 0; rsp_dat = 0; rsp_err = 1; go to RESP.
  - Ack in the same cycle as timeout expiry: ack wins (rsp_err = 0).
- RESP: rsp_valid = 1, with rsp_dat and rsp_err stable until rsp_ready.
  - On handshake: rsp_valid = 0, go to IDLE.
  - Next command earliest: cyc re-asserts 2 edges after the response handshake (RESP -> IDLE -> BUS).
  - The FIFO continues accepting commands during BUS and RESP.

Bus rules:
- wbm_ack_i is ignored outside BUS, including a stale ack from a slave that still sees stb.
- Exactly one ack is consumed per transaction.
- cyc and stb are always equal.
- Address and data are not modified by this block; alignment is the caller's responsibility.

busy = (state != IDLE) || !empty; registered-output equivalent not required.

Decomposition:
- Shared package wb_cmd_pkg:
  - state encoding localparams (IDLE, BUS, RESP);
  - command record width constant CMD_W = 1 + 32 + 32 + 4 = 69;
  - bit-field offsets of we/adr/dat/sel within the packed command word.
- One natural sub-module: wb_cmd_fifo.
  - Synchronous FIFO, parameters WIDTH = CMD_W and AW = FIFO_AW.
  - Same asynchronous active-high reset.
  - Outputs full/empty, with first-word data valid while non-empty.
- The master FSM, timeout counter and response registers stay in wb_cmd_master.

Test Plan:
1. Write: cmd we = 1, adr = 32'h3000_0000, dat = 32'hA5A5_0001, sel = 4'hF, against a slave acking 1 cycle after stb -> one cyc/stb pulse of 2 cycles with stable fields; rsp_valid with rsp_err = 0, rsp_dat = 0.
2. Read: slave returns 32'h0000_1234 with ack -> rsp_dat = 32'h0000_1234, rsp_err = 0; cyc falls at the ack edge; a second (stale) ack next cycle is ignored and no extra response appears.
3. Timeout: TIMEOUT = 8, slave never acks -> cyc high for exactly 8 cycles, then rsp_err = 1, rsp_dat = 0; the next queued command proceeds normally.
4. Backpressure: hold rsp_ready = 0 and push 6 commands -> cmd_ready drops after 4 accepted plus 1 in flight; releasing rsp_ready drains all in order, with addresses matching push order.
5. Reset mid-transaction: assert wb_rst_i while cyc = 1 -> cyc/stb/rsp_valid/busy go 0 without waiting for a clock edge; after release, cmd_ready = 1 and no response is emitted for the aborted command.
6. Ack coinciding with timeout expiry: TIMEOUT = 4, ack in the 4th cycle -> rsp_err = 0 with the slave's data captured.
